// File: rtl/prog_loader.sv
// prog_loader: sequences instruction words into per-core instruction memories with auto-incrementing
// address, optional broadcast to every core, abort, and a completion pulse.
module prog_loader #(
   parameter int LOG_CORES   = 3,
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [LOG_CORES-1:0]   cmd_sel,
   input  logic                   cmd_bcast,
   input  logic [PC_WIDTH-1:0]    cmd_base,
   input  logic [PC_WIDTH:0]      cmd_len,
   input  logic                   word_valid,
   output logic                   word_ready,
   input  logic [INSTR_WIDTH-1:0] word_data,
   input  logic                   abort,
   output logic                   prog_we,
   output logic [LOG_CORES-1:0]   prog_sel,
   output logic [PC_WIDTH-1:0]    prog_waddr,
   output logic [INSTR_WIDTH-1:0] prog_wdata,
   output logic                   busy,
   output logic                   done
);
   localparam int N = 2**LOG_CORES;
   localparam logic [LOG_CORES-1:0] PENULT_SEL = LOG_CORES'(N - 2);
   localparam logic [PC_WIDTH:0] K_ONE = (PC_WIDTH+1)'(1);
   typedef enum logic [1:0] {IDLE, STREAM, BCAST, DONE} state_t;
   state_t r_state, w_state;
   logic [LOG_CORES-1:0]   r_sel, r_psel, w_psel;
   logic                   r_bcast, r_we, w_we, r_done, w_done, w_cmd_acc, w_word_acc;
   logic [PC_WIDTH-1:0]    r_base, r_waddr, w_waddr;
   logic [PC_WIDTH:0]      r_len, r_k, w_k;
   logic [INSTR_WIDTH-1:0] r_wdata, w_wdata;
   assign cmd_ready  = (r_state == IDLE) && !wb_rst_i;
   assign word_ready = (r_state == STREAM) && !abort && !wb_rst_i;
   assign w_cmd_acc  = cmd_valid && cmd_ready;
   assign w_word_acc = word_valid && word_ready;
   assign busy       = r_state != IDLE;
   assign done       = r_done;
   assign prog_we    = r_we;
   assign prog_sel   = r_psel;
   assign prog_waddr = r_waddr;
   assign prog_wdata = r_wdata;
   always_comb begin
      w_state = r_state;
      w_we    = 1'b0;
      w_psel  = '0;
      w_waddr = '0;
      w_wdata = '0;
      w_k     = r_k;
      w_done  = 1'b0;
      case (r_state)
         IDLE: if (w_cmd_acc) begin
            w_k     = '0;
            w_state = (cmd_len == '0) ? DONE : STREAM;
         end
         STREAM: if (w_word_acc) begin
            w_we    = 1'b1;
            w_psel  = r_bcast ? '0 : r_sel;
            w_waddr = r_base + r_k[PC_WIDTH-1:0];
            w_wdata = word_data;
            w_k     = r_k + K_ONE;
            w_state = r_bcast ? BCAST : ((r_k + K_ONE == r_len) ? DONE : STREAM);
         end
         // replay the held word to the remaining cores; leave while the last core's write is queued
         BCAST: begin
            w_we    = 1'b1;
            w_psel  = r_psel + LOG_CORES'(1);
            w_waddr = r_waddr;
            w_wdata = r_wdata;
            if (r_psel == PENULT_SEL) w_state = (r_k == r_len) ? DONE : STREAM;
         end
         DONE: begin
            w_state = IDLE;
            w_done  = 1'b1;
         end
         default: w_state = IDLE;
      endcase
      if (abort && r_state != IDLE) begin
         w_state = IDLE;
         w_we    = 1'b0;
         w_psel  = '0;
         w_waddr = '0;
         w_wdata = '0;
         w_done  = 1'b0;
      end
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_bcast <= 1'b0;
         r_base  <= '0;
         r_len   <= '0;
         r_k     <= '0;
         r_we    <= 1'b0;
         r_psel  <= '0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_k     <= w_k;
         r_we    <= w_we;
         r_psel  <= w_psel;
         r_waddr <= w_waddr;
         r_wdata <= w_wdata;
         r_done  <= w_done;
         if (w_cmd_acc) begin
            r_sel   <= cmd_sel;
            r_bcast <= cmd_bcast;
            r_base  <= cmd_base;
            r_len   <= cmd_len;
         end
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed checks of prog_loader streaming, wrap, broadcast, abort and zero-length loads.
module tb_prog_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst, cmd_valid, cmd_ready, cmd_bcast, word_valid, word_ready, abort;
   logic        prog_we, busy, done;
   logic [2:0]  cmd_sel, prog_sel;
   logic [7:0]  cmd_base, prog_waddr;
   logic [8:0]  cmd_len;
   logic [31:0] word_data, prog_wdata;
   prog_loader #(.LOG_CORES(3), .PC_WIDTH(8), .INSTR_WIDTH(32)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sel(cmd_sel), .cmd_bcast(cmd_bcast), .cmd_base(cmd_base), .cmd_len(cmd_len),
      .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data), .abort(abort),
      .prog_we(prog_we), .prog_sel(prog_sel), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
      .busy(busy), .done(done)
   );
   int checks = 0, failures = 0, cyc = 0;
   int nw = 0, nd = 0, idle_nz = 0, stalls = 0, cmd_cyc = 0;
   int lg_cyc[64], d_cyc[8], acc_cyc[8];
   logic [2:0]  lg_sel[64];
   logic [7:0]  lg_addr[64];
   logic [31:0] lg_data[64];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (prog_we === 1'b1 && nw < 64) begin
         lg_cyc[nw] = cyc; lg_sel[nw] = prog_sel; lg_addr[nw] = prog_waddr; lg_data[nw] = prog_wdata;
         nw++;
      end
      if (prog_we === 1'b0 && (prog_sel !== 0 || prog_waddr !== 0 || prog_wdata !== 0)) idle_nz++;
      if (done === 1'b1 && nd < 8) begin d_cyc[nd] = cyc; nd++; end
   end
   task automatic step();
      @(posedge clk); #1;
   endtask
   task automatic clear_logs();
      nw = 0; nd = 0; stalls = 0;
   endtask
   task automatic issue_cmd(input logic [2:0] sel, input logic bc, input logic [7:0] base, input logic [8:0] len);
      int w = 0;
      cmd_sel = sel; cmd_bcast = bc; cmd_base = base; cmd_len = len; cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && w < 50) begin step(); w++; end
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd_ready_wait got=%b want=1", cmd_ready); end
      cmd_cyc = cyc;
      step();
      cmd_valid = 1'b0;
   endtask
   task automatic stream(input int n, input logic [31:0] d0, input int gap);
      for (int i = 0; i < n; i++) begin
         int w = 0;
         if (i == gap) step();
         word_valid = 1'b1; word_data = d0 + i;
         while (word_ready !== 1'b1 && w < 50) begin if (busy) stalls++; step(); w++; end
         if (word_ready !== 1'b1) begin checks++; failures++; $display("FAIL word_ready_wait word=%0d got=%b want=1", i, word_ready); end
         acc_cyc[i] = cyc;
         step();
         word_valid = 1'b0; word_data = '0;
      end
   endtask
   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b1; cmd_len = 9'd3; word_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({cmd_ready, word_ready, prog_we, busy, done} !== 5'b0) begin
            failures++; $display("FAIL reset_outputs cyc=%0d got=%b want=00000", i, {cmd_ready, word_ready, prog_we, busy, done});
         end
      end
      rst = 1'b0; cmd_valid = 1'b0; word_valid = 1'b0; #1;
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
      step();
      checks++;
      if (busy !== 1'b0 || nw != 0) begin failures++; $display("FAIL reset_no_accept busy=%b writes=%0d want 0/0", busy, nw); end
   endtask
   task automatic test_stream();
      clear_logs();
      issue_cmd(3'd5, 1'b0, 8'h10, 9'd3);
      stream(3, 32'hA5A5_0000, -1);
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL stream_done_busy busy=%b done=%b want 0/1", busy, done); end
      step(); step();
      checks++;
      if (nw != 3) begin failures++; $display("FAIL stream_count got=%0d want=3", nw); end
      for (int i = 0; i < 3 && i < nw; i++) begin
         checks++;
         if (lg_cyc[i] != acc_cyc[i] + 1 || lg_sel[i] !== 3'd5 || lg_addr[i] !== 8'h10 + 8'(i) || lg_data[i] !== 32'hA5A5_0000 + i) begin
            failures++;
            $display("FAIL stream_write%0d got cyc=%0d sel=%0d addr=%h data=%h want cyc=%0d sel=5 addr=%h data=%h",
                     i, lg_cyc[i], lg_sel[i], lg_addr[i], lg_data[i], acc_cyc[i] + 1, 8'h10 + 8'(i), 32'hA5A5_0000 + i);
         end
      end
      checks++;
      if (nd != 1 || d_cyc[0] != acc_cyc[0] + 4) begin failures++; $display("FAIL stream_done n=%0d cyc=%0d want n=1 cyc=%0d", nd, d_cyc[0], acc_cyc[0] + 4); end
   endtask
   task automatic test_wrap();
      logic [7:0] exp_addr[4];
      exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      clear_logs();
      issue_cmd(3'd2, 1'b0, 8'hFE, 9'd4);
      stream(4, 32'h0000_1230, 2);
      repeat (4) step();
      checks++;
      if (nw != 4) begin failures++; $display("FAIL wrap_count got=%0d want=4", nw); end
      for (int i = 0; i < 4 && i < nw; i++) begin
         checks++;
         if (lg_addr[i] !== exp_addr[i] || lg_sel[i] !== 3'd2 || lg_cyc[i] != acc_cyc[i] + 1) begin
            failures++; $display("FAIL wrap_write%0d got addr=%h sel=%0d cyc=%0d want addr=%h sel=2 cyc=%0d",
                                 i, lg_addr[i], lg_sel[i], lg_cyc[i], exp_addr[i], acc_cyc[i] + 1);
         end
      end
      checks++;
      if (lg_cyc[2] - lg_cyc[1] != 2 || lg_cyc[3] - lg_cyc[2] != 1) begin
         failures++; $display("FAIL wrap_gap got spacing=%0d,%0d want 2,1", lg_cyc[2] - lg_cyc[1], lg_cyc[3] - lg_cyc[2]);
      end
      checks++;
      if (nd != 1 || d_cyc[0] != acc_cyc[3] + 2) begin failures++; $display("FAIL wrap_done n=%0d cyc=%0d want n=1 cyc=%0d", nd, d_cyc[0], acc_cyc[3] + 2); end
   endtask
   task automatic test_bcast();
      clear_logs();
      issue_cmd(3'd3, 1'b1, 8'h20, 9'd2);
      stream(2, 32'hBEEF_0000, -1);
      repeat (12) step();
      checks++;
      if (nw != 16) begin failures++; $display("FAIL bcast_count got=%0d want=16", nw); end
      for (int i = 0; i < 16 && i < nw; i++) begin
         checks++;
         if (lg_sel[i] !== 3'(i % 8) || lg_addr[i] !== 8'h20 + 8'(i / 8) || lg_data[i] !== 32'hBEEF_0000 + i / 8 || lg_cyc[i] != acc_cyc[0] + 1 + i) begin
            failures++; $display("FAIL bcast_write%0d got sel=%0d addr=%h data=%h cyc=%0d want sel=%0d addr=%h data=%h cyc=%0d",
                                 i, lg_sel[i], lg_addr[i], lg_data[i], lg_cyc[i], i % 8, 8'h20 + 8'(i / 8), 32'hBEEF_0000 + i / 8, acc_cyc[0] + 1 + i);
         end
      end
      checks++;
      if (stalls != 7 || acc_cyc[1] != acc_cyc[0] + 8) begin failures++; $display("FAIL bcast_ready stalls=%0d gap=%0d want 7/8", stalls, acc_cyc[1] - acc_cyc[0]); end
      checks++;
      if (nd != 1 || d_cyc[0] != acc_cyc[0] + 17) begin failures++; $display("FAIL bcast_done n=%0d cyc=%0d want n=1 cyc=%0d", nd, d_cyc[0], acc_cyc[0] + 17); end
   endtask
   task automatic test_abort();
      clear_logs();
      issue_cmd(3'd4, 1'b0, 8'h40, 9'd5);
      stream(2, 32'hC0DE_0000, -1);
      abort = 1'b1; word_valid = 1'b1; word_data = 32'hDEAD_DEAD; #1;
      checks++;
      if (word_ready !== 1'b0) begin failures++; $display("FAIL abort_word_ready got=%b want=0", word_ready); end
      step();
      abort = 1'b0; word_valid = 1'b0; word_data = '0;
      checks++;
      if (prog_we !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL abort_state we=%b cmd_ready=%b busy=%b want 0/1/0", prog_we, cmd_ready, busy);
      end
      repeat (3) step();
      checks++;
      if (nd != 0 || nw != 2) begin failures++; $display("FAIL abort_drop done=%0d writes=%0d want 0/2", nd, nw); end
      clear_logs();
      issue_cmd(3'd1, 1'b0, 8'h00, 9'd1);
      stream(1, 32'h1234_5678, -1);
      repeat (3) step();
      checks++;
      if (nw != 1 || lg_sel[0] !== 3'd1 || lg_addr[0] !== 8'h00 || lg_data[0] !== 32'h1234_5678) begin
         failures++; $display("FAIL abort_reload n=%0d sel=%0d addr=%h data=%h want 1/1/00/12345678", nw, lg_sel[0], lg_addr[0], lg_data[0]);
      end
      checks++;
      if (nd != 1 || d_cyc[0] != acc_cyc[0] + 2) begin failures++; $display("FAIL abort_reload_done n=%0d cyc=%0d want n=1 cyc=%0d", nd, d_cyc[0], acc_cyc[0] + 2); end
   endtask
   task automatic test_len_zero();
      clear_logs();
      issue_cmd(3'd6, 1'b0, 8'h55, 9'd0);
      checks++;
      if (busy !== 1'b1 || word_ready !== 1'b0) begin failures++; $display("FAIL zero_busy busy=%b word_ready=%b want 1/0", busy, word_ready); end
      repeat (4) step();
      checks++;
      if (nw != 0 || nd != 1 || d_cyc[0] != cmd_cyc + 2) begin
         failures++; $display("FAIL zero_done writes=%0d n=%0d cyc=%0d want 0/1/%0d", nw, nd, d_cyc[0], cmd_cyc + 2);
      end
   endtask
   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_sel = '0; cmd_bcast = 1'b0; cmd_base = '0; cmd_len = '0;
      word_valid = 1'b0; word_data = '0; abort = 1'b0;
      test_reset();
      test_stream();
      test_wrap();
      test_bcast();
      test_abort();
      test_len_zero();
      checks++;
      if (idle_nz != 0) begin failures++; $display("FAIL idle_zero got=%0d nonzero idle cycles want=0", idle_nz); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
